accum_seq: RTL and testbench
============================

ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2: data and accumulator width in bits, legal range 1..16.
REQ-002 The block SHALL have parameter LIMIT, default 16: number of accepted samples per run, legal range 1..255.
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have a port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have a port enable, input, 1 bit: sample-accept strobe, sampled at the rising edge of clk.
REQ-006 The block SHALL have a port clear, input, 1 bit: synchronous restart of the run.
REQ-007 The block SHALL have a port mode, input, 2 bits: 00 wrap-add, 01 wrap-sub, 10 saturating-add, 11 saturating-sub.
REQ-008 The block SHALL have a port din, input, WIDTH bits: input code, encoded MSB-first (for WIDTH=2, din = {A,B}).
REQ-009 The block SHALL have a port cod_out, output, WIDTH bits: registered copy of the last accepted din.
REQ-010 The block SHALL have a port sum_out, output, WIDTH bits: accumulator value.
REQ-011 The block SHALL have a port count, output, 8 bits: number of samples accepted in the current run.
REQ-012 The block SHALL have a port valid, output, 1 bit: one-cycle pulse after each accepted sample.
REQ-013 The block SHALL have a port ovf, output, 1 bit: sticky flag for wrap or clamp events.
REQ-014 The block SHALL have a port done, output, 1 bit: high when the run holds LIMIT samples.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 The block SHALL move from IDLE to RUN on the first accepted sample.
REQ-017 The block SHALL move from RUN to DONE on the edge where count becomes LIMIT.
REQ-018 The block SHALL move from DONE to IDLE only on clear.
REQ-019 A sample SHALL be accepted at a rising clk edge when enable=1, clear=0 and state is not DONE.
REQ-020 In DONE, enable SHALL be ignored: no update, no valid pulse.
REQ-021 On acceptance, cod_out SHALL be loaded with din.
REQ-022 On acceptance, sum_out SHALL be loaded with f(sum_out, din, mode) per REQ-027 to REQ-029.
REQ-023 On acceptance, count SHALL increment by 1.
REQ-024 On acceptance, valid SHALL be 1 for exactly the following cycle.
REQ-025 Latency SHALL be one cycle: results are visible right after the accepting edge, with no combinational path from din to any output.
REQ-026 When enable is held high, the block SHALL accept one sample per cycle.
REQ-027 In wrap modes, sum_out SHALL be (sum_out +/- din) mod 2^WIDTH.
REQ-028 In wrap modes, ovf SHALL be set on carry-out (add) or borrow (sub).
REQ-029 In saturating modes, sum_out SHALL clamp to 2^WIDTH-1 (add) or 0 (sub), and ovf SHALL be set when a clamp occurs.
REQ-030 mode SHALL be sampled per accepted sample, so modes may change between samples.
REQ-031 ovf SHALL stay set until clear or reset.
REQ-032 On clear, the block SHALL return to IDLE.
REQ-033 On clear, sum_out, cod_out, count and ovf SHALL become 0, and valid and done SHALL become 0 on the next edge.
REQ-034 When clear and enable are both high on the same edge, clear SHALL win and the sample SHALL be discarded.
REQ-035 done SHALL equal (state == DONE), registered.
REQ-036 count SHALL never exceed LIMIT.

Reset
REQ-037 While reset=0, the block SHALL force state IDLE and all outputs (cod_out, sum_out, count, valid, ovf, done) to 0 immediately, independent of clk.
REQ-038 Reset asserted mid-run SHALL abort the run with no partial update.
REQ-039 After reset is released, the first accepted sample SHALL be taken at the first rising edge on which enable=1.

Verification
REQ-040 The bench SHALL cover: WIDTH=2, mode=00; din 01, 10, 11 each on a single-cycle enable -> sum_out 01, 11, 10; ovf rises after the third sample; count=3; valid pulses 3 times.
REQ-041 The bench SHALL cover: WIDTH=2, mode=10; din 11, 11 -> sum_out 11, 11 (clamped); ovf=1 after the second sample.
REQ-042 The bench SHALL cover: WIDTH=2, mode=01 from sum=01; din 10 -> sum_out 11; ovf=1 (borrow).
REQ-043 The bench SHALL cover: LIMIT=4 with enable held high for 6 cycles -> count stops at 4; done=1; sum_out frozen after the 4th sample; no valid pulse in cycles 5 and 6.
REQ-044 The bench SHALL cover: clear and enable both high with din=01 -> all outputs 0 and state IDLE; the sample is not counted.
REQ-045 The bench SHALL cover: reset=0 driven between clock edges mid-run -> outputs read 0 before the next edge; after release, din=01 gives sum_out=01 and count=1.

Source files
------------

// File: rtl/accum_seq.sv
// accum_seq: run-based accumulator with wrap/saturating add/sub modes.
// A run accepts up to LIMIT samples, then holds in DONE until cleared.
// All outputs come straight from registers, so din never reaches an
// output combinationally.
module accum_seq #(
    parameter int WIDTH = 2,
    parameter int LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cod_out,
    output logic [WIDTH-1:0] sum_out,
    output logic [7:0]       count,
    output logic             valid,
    output logic             ovf,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    // One accumulation step: returns {overflow_event, new_sum}.
    // The event bit is the carry (add) or borrow (sub); in saturating
    // modes the same event selects the clamp value.
    function automatic logic [WIDTH:0] step_fn(
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] din_v,
        input logic [1:0]       mode_v
    );
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] res;
        logic             evt;
        if (mode_v[0] == 1'b0) begin
            ext = {1'b0, acc} + {1'b0, din_v};
        end else begin
            ext = {1'b0, acc} - {1'b0, din_v};
        end
        evt = ext[WIDTH];
        case (mode_v)
            2'b00, 2'b01: res = ext[WIDTH-1:0];
            2'b10:        res = evt ? {WIDTH{1'b1}} : ext[WIDTH-1:0];
            2'b11:        res = evt ? {WIDTH{1'b0}} : ext[WIDTH-1:0];
            default:      res = ext[WIDTH-1:0];
        endcase
        return {evt, res};
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;
    logic [7:0]       count_next_s;
    logic [WIDTH:0]   step_s;

    logic [WIDTH-1:0] cod_r;
    logic [WIDTH-1:0] sum_r;
    logic [7:0]       count_r;
    logic             valid_r;
    logic             ovf_r;
    logic             done_r;

    assign accept_s     = enable && !clear && (state_r != DONE);
    assign count_next_s = count_r + 8'd1;
    assign step_s       = step_fn(sum_r, din, mode);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: clear always returns to IDLE; the sample that
    // brings count to LIMIT moves the run into DONE.
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE, RUN: begin
                    if (accept_s) begin
                        if (count_next_s == LIMIT_C) begin
                            state_next_s = DONE;
                        end else begin
                            state_next_s = RUN;
                        end
                    end else begin
                        state_next_s = state_r;
                    end
                end
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Datapath and flag registers: load on acceptance, zero on clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cod_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            count_r <= 8'd0;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
        end else if (clear) begin
            cod_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            count_r <= 8'd0;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
        end else if (accept_s) begin
            cod_r   <= din;
            sum_r   <= step_s[WIDTH-1:0];
            count_r <= count_next_s;
            valid_r <= 1'b1;
            ovf_r   <= ovf_r | step_s[WIDTH];
            done_r  <= (state_next_s == DONE);
        end else begin
            valid_r <= 1'b0;
            done_r  <= (state_next_s == DONE);
        end
    end

    assign cod_out = cod_r;
    assign sum_out = sum_r;
    assign count   = count_r;
    assign valid   = valid_r;
    assign ovf     = ovf_r;
    assign done    = done_r;

endmodule

// File: tb/tb_accum_seq.sv
// tb_accum_seq: table-driven directed bench for accum_seq (WIDTH=2, LIMIT=4)
// plus a hand-written asynchronous-reset sequence.
module tb_accum_seq;

    typedef struct {
        string      name;
        logic       en;
        logic       clr;
        logic [1:0] mode;
        logic [1:0] din;
        logic [1:0] exp_sum;
        logic [1:0] exp_cod;
        logic [7:0] exp_cnt;
        logic       exp_valid;
        logic       exp_ovf;
        logic       exp_done;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       clear;
    logic [1:0] mode;
    logic [1:0] din;
    logic [1:0] cod_out;
    logic [1:0] sum_out;
    logic [7:0] count;
    logic       valid;
    logic       ovf;
    logic       done;

    int n_vec;
    int n_bad;
    vec_t vecs[$];

    accum_seq #(.WIDTH(2), .LIMIT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .clear   (clear),
        .mode    (mode),
        .din     (din),
        .cod_out (cod_out),
        .sum_out (sum_out),
        .count   (count),
        .valid   (valid),
        .ovf     (ovf),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input string nm, input logic e, input logic c,
                           input logic [1:0] m, input logic [1:0] d,
                           input logic [1:0] s, input logic [1:0] cd,
                           input logic [7:0] n, input logic v,
                           input logic o, input logic dn);
        vec_t t;
        t.name = nm; t.en = e; t.clr = c; t.mode = m; t.din = d;
        t.exp_sum = s; t.exp_cod = cd; t.exp_cnt = n;
        t.exp_valid = v; t.exp_ovf = o; t.exp_done = dn;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm, input logic [1:0] s,
                         input logic [1:0] cd, input logic [7:0] n,
                         input logic v, input logic o, input logic dn);
        n_vec++;
        if (sum_out !== s || cod_out !== cd || count !== n ||
            valid !== v || ovf !== o || done !== dn) begin
            n_bad++;
            $display("FAIL %s: got sum=%b cod=%b cnt=%0d valid=%b ovf=%b done=%b, want sum=%b cod=%b cnt=%0d valid=%b ovf=%b done=%b",
                     nm, sum_out, cod_out, count, valid, ovf, done,
                     s, cd, n, v, o, dn);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        mode   = 2'b00;
        din    = 2'b00;

        //       name          en    clr   mode   din    sum    cod    cnt   v     ovf   done
        // wrap-add 01,10,11 with single-cycle enables
        add_vec("wadd_1",      1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 2'b01, 8'd1, 1'b1, 1'b0, 1'b0);
        add_vec("wadd_gap1",   1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 2'b01, 8'd1, 1'b0, 1'b0, 1'b0);
        add_vec("wadd_2",      1'b1, 1'b0, 2'b00, 2'b10, 2'b11, 2'b10, 8'd2, 1'b1, 1'b0, 1'b0);
        add_vec("wadd_gap2",   1'b0, 1'b0, 2'b00, 2'b01, 2'b11, 2'b10, 8'd2, 1'b0, 1'b0, 1'b0);
        add_vec("wadd_3",      1'b1, 1'b0, 2'b00, 2'b11, 2'b10, 2'b11, 8'd3, 1'b1, 1'b1, 1'b0);
        add_vec("wadd_hold",   1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b11, 8'd3, 1'b0, 1'b1, 1'b0);
        add_vec("clr_a",       1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        // saturating add clamps at 11
        add_vec("sadd_1",      1'b1, 1'b0, 2'b10, 2'b11, 2'b11, 2'b11, 8'd1, 1'b1, 1'b0, 1'b0);
        add_vec("sadd_clamp",  1'b1, 1'b0, 2'b10, 2'b11, 2'b11, 2'b11, 8'd2, 1'b1, 1'b1, 1'b0);
        add_vec("clr_b",       1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        // wrap-sub borrow from 01 - 10
        add_vec("wsub_pre",    1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 2'b01, 8'd1, 1'b1, 1'b0, 1'b0);
        add_vec("wsub_borrow", 1'b1, 1'b0, 2'b01, 2'b10, 2'b11, 2'b10, 8'd2, 1'b1, 1'b1, 1'b0);
        // clear wins over enable
        add_vec("clr_en",      1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        // enable held for 6 cycles, LIMIT=4
        add_vec("lim_1",       1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 2'b01, 8'd1, 1'b1, 1'b0, 1'b0);
        add_vec("lim_2",       1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b01, 8'd2, 1'b1, 1'b0, 1'b0);
        add_vec("lim_3",       1'b1, 1'b0, 2'b00, 2'b01, 2'b11, 2'b01, 8'd3, 1'b1, 1'b0, 1'b0);
        add_vec("lim_4",       1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 8'd4, 1'b1, 1'b1, 1'b1);
        add_vec("lim_5",       1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 8'd4, 1'b0, 1'b1, 1'b1);
        add_vec("lim_6",       1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b01, 8'd4, 1'b0, 1'b1, 1'b1);
        add_vec("clr_done",    1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        // saturating sub clamps at 0; mode changes per sample; ovf sticky
        add_vec("ssub_clamp",  1'b1, 1'b0, 2'b11, 2'b01, 2'b00, 2'b01, 8'd1, 1'b1, 1'b1, 1'b0);
        add_vec("sadd_sticky", 1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 2'b10, 8'd2, 1'b1, 1'b1, 1'b0);
        add_vec("ssub_noclmp", 1'b1, 1'b0, 2'b11, 2'b01, 2'b01, 2'b01, 8'd3, 1'b1, 1'b1, 1'b0);
        add_vec("clr_c",       1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);

        // reset held across clock edges: outputs must stay zero
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en;
            clear  = vecs[i].clr;
            mode   = vecs[i].mode;
            din    = vecs[i].din;
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_cod,
                  vecs[i].exp_cnt, vecs[i].exp_valid, vecs[i].exp_ovf,
                  vecs[i].exp_done);
        end

        // mid-run asynchronous reset between edges
        enable = 1'b1; clear = 1'b0; mode = 2'b00; din = 2'b11;
        @(posedge clk);
        #1;
        check("pre_rst_1", 2'b11, 2'b11, 8'd1, 1'b1, 1'b0, 1'b0);
        din = 2'b10;
        @(posedge clk);
        #1;
        check("pre_rst_2", 2'b01, 2'b10, 8'd2, 1'b1, 1'b1, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst", 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        din    = 2'b01;
        @(posedge clk);
        #1;
        check("post_rst", 2'b01, 2'b01, 8'd1, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", 2'b01, 2'b01, 8'd1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
